// File: rtl/umul_add_seq_pkg.sv
// Shared constants and state encoding for the sequential multiply-add (A*B+C).
package umul_add_seq_pkg;

  localparam int unsigned UmulWidth = 32;
  localparam int unsigned UmulIters = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/umuladd_adder64.sv
// Ripple-carry adder made of chained full-add cells; carry out is exported for the caller.
module umuladd_adder64 #(
  parameter int unsigned Width = 64
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o,
  output logic             cout_o
);

  always_comb begin
    logic c;
    c      = 1'b0;
    sum_o  = '0;
    for (int i = 0; i < Width; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/umul_add_seq.sv
// Sequential shift-add multiplier computing Product = A*B + C, one partial product per cycle.
// Optional macro UMULADD_EARLY_TERM_EN stops as soon as the remaining multiplier bits are zero.
module umul_add_seq
  import umul_add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = UmulWidth
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  input  logic [WIDTH-1:0]   Addend,
  output logic [2*WIDTH-1:0] Product,
  output logic               busy,
  output logic               done
);

  localparam int unsigned AccW = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(UmulIters);
  localparam logic [CntW-1:0] LastCnt = CntW'(UmulIters - 1);

  state_e          state_q, state_d;
  logic [AccW-1:0] a_q, a_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AccW-1:0] pp;
  logic [AccW-1:0] sum;
  logic            sum_unused_carry;
  logic            last_iter;

  // a_q holds A already shifted by the iteration count, so no barrel shifter is needed.
  assign pp = b_q[0] ? a_q : '0;

  umuladd_adder64 #(
    .Width (AccW)
  ) u_adder (
    .a_i    (acc_q),
    .b_i    (pp),
    .sum_o  (sum),
    .cout_o (sum_unused_carry)
  );

`ifdef UMULADD_EARLY_TERM_EN
  assign last_iter = (cnt_q == LastCnt) || (b_q[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt_q == LastCnt);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = AccW'(Multiplicand);
          b_d     = Multiplier;
          acc_d   = AccW'(Addend);
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Product = acc_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_umul_add_seq.sv
// Directed bench for umul_add_seq: reset, arithmetic vectors, latency, start masking, abort.
module tb_umul_add_seq;

`ifdef UMULADD_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] addend;
  logic [63:0] product;
  logic        busy;
  logic        done;

  int nvec;
  int nerr;

  umul_add_seq #(
    .WIDTH (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .Multiplicand (mcand),
    .Multiplier   (mplier),
    .Addend       (addend),
    .Product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycles from the start-sampling cycle (counted as 1) to the DONE cycle.
  function automatic int exp_lat(input logic [31:0] b);
    int m;
    m = 0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) m = i;
    end
    return EarlyTerm ? (m + 2) : 33;
  endfunction

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [63:0] exp_p);
    int n;
    mcand  = a;
    mplier = b;
    addend = c;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({name, "_load"}, product, {32'h0, c});
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_lat"}, n, exp_lat(b));
    chk({name, "_prod"}, product, exp_p);
    @(posedge clk);
    #1;
    chk({name, "_pulse"}, {busy, done}, 0);
    chk({name, "_hold"}, product, exp_p);
  endtask

  initial begin
    int          n;
    int          seen;
    logic [31:0] dvd;
    logic [31:0] dvs;

    nvec   = 0;
    nerr   = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    addend = '0;

    #12;
    chk("rst_prod", product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("v7x6p5", 32'd7, 32'd6, 32'd5, 64'h2F);
    run_op("vmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
    run_op("div7x14p2", 32'd7, 32'd14, 32'd2, 64'd100);
    run_op("v9x1p3", 32'd9, 32'd1, 32'd3, 64'd12);
    run_op("bzero", 32'd5, 32'd0, 32'h1234, 64'h1234);
    run_op("bmsb", 32'd3, 32'h8000_0000, 32'd1, 64'h1_8000_0001);

    // Divider round-trip: divisor * quotient + remainder must rebuild the dividend.
    for (int k = 0; k < 4; k++) begin
      dvd = $urandom;
      dvs = $urandom_range(1, 32'hFFFF);
      run_op("divrt", dvs, dvd / dvs, dvd % dvs, {32'h0, dvd});
    end

    // Start re-pulsed mid-RUN with other operands must be ignored.
    mcand  = 32'd7;
    mplier = 32'd6;
    addend = 32'd5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      if (n == 2) begin
        mcand  = 32'd100;
        mplier = 32'd200;
        addend = 32'd300;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("ign_run_lat", n, exp_lat(32'd6));
    chk("ign_run_prod", product, 64'h2F);
    // Start held during the DONE cycle is likewise dropped.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign_done_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("ign_done_idle", busy, 0);
    chk("ign_done_prod", product, 64'h2F);

    // Asynchronous abort during RUN.
    mcand  = 32'hFFFF_FFFF;
    mplier = 32'hFFFF_FFFF;
    addend = 32'd9;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_prod", product, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("abort_quiet", seen, 0);
    run_op("after_abort", 32'd7, 32'd14, 32'd2, 64'd100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
